// File: rtl/arty_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : arty_input_cond
//  Purpose  : Conditions the Arty push-buttons and slide switches. Each raw
//             pin is synchronised to clk, debounced independently, and
//             presented as a clean level plus one-cycle edge pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module arty_input_cond #(
    parameter int BTN_WIDTH       = 4,    // button channels
    parameter int SW_WIDTH        = 2,    // switch channels
    parameter int SYNC_STAGES     = 2,    // synchroniser depth, >= 2
    parameter int DEBOUNCE_CYCLES = 1000  // cycles a new level must hold, >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_WIDTH-1:0] btn_i,
    input  logic [SW_WIDTH-1:0]  sw_i,
    output logic [BTN_WIDTH-1:0] btn_o,
    output logic [BTN_WIDTH-1:0] btn_press_o,
    output logic [BTN_WIDTH-1:0] btn_release_o,
    output logic [SW_WIDTH-1:0]  sw_o,
    output logic [SW_WIDTH-1:0]  sw_change_o
);

    // Buttons occupy the low channel indices, switches sit above them.
    localparam int c_num_chans = BTN_WIDTH + SW_WIDTH;
    localparam int c_cnt_w     = $clog2(DEBOUNCE_CYCLES + 1);

    // Counter value on which a persistent new level is accepted; the counter
    // therefore never exceeds this and cannot wrap.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_num_chans-1:0] w_raw;
    logic [c_num_chans-1:0] w_synced;
    logic [c_num_chans-1:0] w_stable;
    logic [c_num_chans-1:0] w_rise;
    logic [c_num_chans-1:0] w_fall;

    logic [c_num_chans-1:0] r_sync [SYNC_STAGES];

    assign w_raw = {sw_i, btn_i};

    // Multi-flop synchroniser chain per bit; only the final stage is trusted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    generate
        for (genvar ch = 0; ch < c_num_chans; ch++) begin : g_chan
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_stable;
            logic               r_rise;
            logic               r_fall;

            // Debouncer: accept a new level only after it has been seen on
            // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted
            // level discards the partial count. Edge pulses are raised on the
            // same edge the accepted level changes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_synced[ch] == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_stable <= w_synced[ch];
                        r_cnt    <= '0;
                        r_rise   <= w_synced[ch];
                        r_fall   <= ~w_synced[ch];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
            end

            assign w_stable[ch] = r_stable;
            assign w_rise[ch]   = r_rise;
            assign w_fall[ch]   = r_fall;
        end
    endgenerate

    assign btn_o         = w_stable[BTN_WIDTH-1:0];
    assign btn_press_o   = w_rise[BTN_WIDTH-1:0];
    assign btn_release_o = w_fall[BTN_WIDTH-1:0];
    assign sw_o          = w_stable[c_num_chans-1:BTN_WIDTH];
    // Rise and fall are mutually exclusive flops, so their OR is still a
    // clean single-cycle pulse with no path back to the pins.
    assign sw_change_o   = w_rise[c_num_chans-1:BTN_WIDTH] | w_fall[c_num_chans-1:BTN_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_arty_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arty_input_cond
//  Purpose  : Self-checking bench for arty_input_cond (DEBOUNCE_CYCLES=4,
//             SYNC_STAGES=2) with a run-length reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arty_input_cond;

    localparam int BTN_W = 4;
    localparam int SW_W  = 2;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int NCH   = BTN_W + SW_W;
    localparam int LAT   = SYNC + DEB;   // edges from first sample to update

    logic             clk = 1'b0;
    logic             rst_n;
    logic [BTN_W-1:0] btn_i;
    logic [SW_W-1:0]  sw_i;
    logic [BTN_W-1:0] btn_o;
    logic [BTN_W-1:0] btn_press_o;
    logic [BTN_W-1:0] btn_release_o;
    logic [SW_W-1:0]  sw_o;
    logic [SW_W-1:0]  sw_change_o;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model state: a delay line standing in for the synchroniser,
    // plus, per channel, the length of the current run of identical values.
    logic [NCH-1:0] m_pipe [$];
    logic [NCH-1:0] m_stable;
    logic [NCH-1:0] m_rise;
    logic [NCH-1:0] m_fall;
    logic           m_last [NCH];
    int             m_run  [NCH];

    arty_input_cond #(
        .BTN_WIDTH      (BTN_W),
        .SW_WIDTH       (SW_W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_i        (btn_i),
        .sw_i         (sw_i),
        .btn_o        (btn_o),
        .btn_press_o  (btn_press_o),
        .btn_release_o(btn_release_o),
        .sw_o         (sw_o),
        .sw_change_o  (sw_change_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        for (int c = 0; c < NCH; c++) begin
            m_last[c] = 1'b0;
            m_run[c]  = 0;
        end
    endtask

    // One clock edge: update the model from the inputs present at the edge,
    // then step 1 time unit past it so outputs are sampled clear of the edge.
    task automatic tick();
        logic [NCH-1:0] seen;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            seen = m_pipe.pop_front();
            m_pipe.push_back({sw_i, btn_i});
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                if (seen[c] == m_last[c]) m_run[c]++;
                else begin
                    m_last[c] = seen[c];
                    m_run[c]  = 1;
                end
                if (seen[c] != m_stable[c] && m_run[c] >= DEB) begin
                    m_stable[c] = seen[c];
                    if (seen[c]) m_rise[c] = 1'b1;
                    else         m_fall[c] = 1'b1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    function automatic logic [17:0] exp_vec();
        return {m_stable[BTN_W-1:0], m_rise[BTN_W-1:0], m_fall[BTN_W-1:0],
                m_stable[NCH-1:BTN_W], m_rise[NCH-1:BTN_W] | m_fall[NCH-1:BTN_W]};
    endfunction

    function automatic logic [17:0] act_vec();
        return {btn_o, btn_press_o, btn_release_o, sw_o, sw_change_o};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            btn_i = BTN_W'($urandom);
            sw_i  = SW_W'($urandom);
            tick();
            checks++;
            if (act_vec() !== 18'd0) $display("FAIL reset_outputs cyc %0d: got %b want 0", cyc, act_vec());
            else passed++;
        end
        btn_i = '0;
        sw_i  = '0;
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_release cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        int pcount = 0, pedge = -1, rcount = 0, redge = -1;
        btn_i[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (btn_press_o[0]) begin pcount++; pedge = k; end
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL clean_press_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pcount !== 1 || pedge !== LAT) $display("FAIL clean_press_edge: got count %0d edge %0d want count 1 edge %0d", pcount, pedge, LAT);
        else passed++;
        checks++;
        if (btn_o !== 4'b0001) $display("FAIL clean_press_level: got %b want 0001", btn_o);
        else passed++;
        btn_i[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_release_o[0]) begin rcount++; redge = k; end
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL clean_release_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (rcount !== 1 || redge !== LAT) $display("FAIL clean_release_edge: got count %0d edge %0d want count 1 edge %0d", rcount, redge, LAT);
        else passed++;
    endtask

    task automatic test_glitch();
        int pulses = 0, pedge = -1, redge = -1;
        btn_i[1] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == DEB - 1) btn_i[1] = 1'b0;
            if (btn_press_o[1] || btn_release_o[1] || btn_o[1]) pulses++;
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL glitch_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL glitch_reject: got %0d active cycles want 0", pulses);
        else passed++;
        btn_i[1] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == DEB) btn_i[1] = 1'b0;
            if (btn_press_o[1])   pedge = k;
            if (btn_release_o[1]) redge = k;
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL glitch_min_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pedge !== LAT || redge !== DEB + LAT) $display("FAIL glitch_min_edges: got press %0d release %0d want press %0d release %0d", pedge, redge, LAT, DEB + LAT);
        else passed++;
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b10101;   // bit k-1 driven before edge k
        int pcount = 0, pedge = -1;
        for (int k = 1; k <= 20; k++) begin
            btn_i[2] = (k <= 5) ? pat[k-1] : 1'b1;
            tick();
            if (btn_press_o[2]) begin pcount++; pedge = k; end
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL bounce_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pcount !== 1 || pedge !== 5 + LAT - 1) $display("FAIL bounce_press: got count %0d edge %0d want count 1 edge %0d", pcount, pedge, 5 + LAT - 1);
        else passed++;
        btn_i[2] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_simultaneous();
        int pedge = -1, cedge = -1, stray = 0;
        logic [BTN_W-1:0] pval = '0;
        logic [SW_W-1:0]  cval = '0;
        btn_i = 4'b1111;
        sw_i  = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_press_o != 0) begin pedge = k; pval = btn_press_o; end
            if (sw_change_o != 0) begin cedge = k; cval = sw_change_o; end
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL simul_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pedge !== LAT || cedge !== LAT || pval !== 4'b1111 || cval !== 2'b11)
            $display("FAIL simul_pulses: got press %b@%0d change %b@%0d want 1111@%0d 11@%0d", pval, pedge, cval, cedge, LAT, LAT);
        else passed++;
        sw_i  = 2'b01;
        cedge = -1;
        cval  = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (sw_change_o != 0) begin cedge = k; cval = sw_change_o; end
            if (btn_press_o != 0 || btn_release_o != 0) stray++;
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL sw_change_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (cedge !== LAT || cval !== 2'b10 || stray !== 0 || sw_o !== 2'b01)
            $display("FAIL sw_change_one: got %b@%0d stray %0d sw_o %b want 10@%0d stray 0 sw_o 01", cval, cedge, stray, sw_o, LAT);
        else passed++;
        btn_i = '0;
        sw_i  = '0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_reset_midcount();
        int pedge = -1, early = 0;
        btn_i[3] = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        rst_n = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (act_vec() !== 18'd0) $display("FAIL midcount_in_reset cyc %0d: got %b want 0", cyc, act_vec());
            else passed++;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_press_o[3]) begin
                if (pedge < 0) pedge = k;
                else early++;
            end
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL midcount_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pedge !== LAT || early !== 0) $display("FAIL midcount_press: got edge %0d extra %0d want edge %0d extra 0", pedge, early, LAT);
        else passed++;
        btn_i[3] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_random();
        logic [NCH-1:0] lvl = '0;
        int hold [NCH];
        for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 2 * DEB + 2);
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    lvl[c]  = ~lvl[c];
                    hold[c] = $urandom_range(1, 2 * DEB + 2);
                end
            end
            {sw_i, btn_i} = lvl;
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL random_model cyc %0d: got %b want %b", cyc, act_vec(), exp_vec());
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_i = '0;
        sw_i  = '0;
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arty_input_cond.md
Name: arty_input_cond

Overview:
- Input-side counterpart to the board LED outputs.
- Conditions the four Arty push-buttons and two slide switches: synchronises them to clk, debounces each channel, and emits clean levels plus one-cycle edge pulses.
- Sits between the top-level board pins and the debug/control logic, which consumes only its outputs and never raw pins.
- Widths match the board package button and switch types (4 and 2 bits).

Parameters:
- BtnWidth, 4, number of button channels (matches board button type).
- SwWidth, 2, number of switch channels (matches board switch type).
- SyncStages, 2, flip-flop stages in each input synchroniser; must be >= 2.
- DebounceCycles, 1000, consecutive cycles a synchronised level must hold before it is accepted; must be >= 1. Board builds override this with a larger value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- btn_i  in  BtnWidth  raw asynchronous button pins
- sw_i  in  SwWidth  raw asynchronous switch pins
- btn_o  out  BtnWidth  debounced button level
- btn_press_o  out  BtnWidth  one-cycle pulse on debounced 0->1
- btn_release_o  out  BtnWidth  one-cycle pulse on debounced 1->0
- sw_o  out  SwWidth  debounced switch level
- sw_change_o  out  SwWidth  one-cycle pulse on any debounced switch change

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset, sampled on a clk edge while rst_n=0, clears:
  - all synchroniser flops, counters and stable registers to 0;
  - all outputs (btn_o, sw_o, all pulse outputs) to 0.
- Synchroniser: per-bit chain of SyncStages flops; only the last stage feeds the debouncer.
- Debouncer: each channel is independent, with a counter of width $clog2(DebounceCycles+1) and a stable register.
  - If synced == stable: counter <= 0.
  - If synced != stable and counter == DebounceCycles-1: stable <= synced, counter <= 0, and the edge pulse is asserted the same cycle stable updates.
  - If synced != stable otherwise: counter increments.
- Latency: with a new level held from the first sampling edge (edge 1), the stable/output update occurs at edge SyncStages+DebounceCycles. Default is edge 1002.
- Glitch rejection:
  - A deviation lasting fewer than DebounceCycles synced cycles produces no output change and no pulse.
  - A return to the stable level mid-count clears the counter; there is no partial credit.
- Pulses:
  - Registered and high for exactly one cycle.
  - btn_press_o and btn_release_o are mutually exclusive per bit.
  - sw_change_o fires on either direction.
- Simultaneous events on different channels produce simultaneous pulses, with no arbitration.
- Outputs are registered: btn_o == stable and sw_o == stable, with no combinational path from inputs.
- Reset mid-count aborts the count and clears outputs. A button held through reset reports a press SyncStages+DebounceCycles edges after rst_n rises. A switch at 1 through reset likewise produces a sw_change_o pulse.
- Counter never wraps: it is bounded by DebounceCycles-1.

Test Plan:
- Use DebounceCycles=4, SyncStages=2.
- Clean press: btn_i[0] 0->1 held 20 cycles -> btn_o[0]=1 and btn_press_o[0]=1 for exactly one cycle at edge 6 after change. No other bits toggle.
- Glitch: btn_i[1]=1 for 3 cycles then 0 -> btn_o[1] stays 0, no pulses. Then repeat with 4 cycles held -> press pulse at edge 6; release pulse 6 edges after the drop.
- Bounce: btn_i[2] toggles 1,0,1,0,1 on consecutive cycles then holds 1 -> exactly one btn_press_o[2] pulse, 6 edges after the final rise.
- Simultaneous: btn_i=4'b1111 and sw_i=2'b11 in the same cycle -> btn_press_o=4'b1111 and sw_change_o=2'b11 on the same cycle. Later sw_i=2'b01 -> sw_change_o=2'b10 only.
- Reset mid-count: press btn_i[3], assert rst_n=0 at edge 4 for 2 cycles while still held -> all outputs 0 during reset, no pulse. btn_press_o[3] fires 6 edges after rst_n=1.
- Reset values: hold rst_n=0 with random btn_i/sw_i -> every output 0 after the first edge.
